// File: rtl/boot_sequencer.sv
// Reboot controller: accepts a boot request or auto-boot timeout, waits for the SPI flash to go
// quiet, applies a delay, then drives a timed active-low user_programn pulse and status LEDs.
module boot_sequencer #(
  parameter int unsigned NUM_IMAGES      = 2,
  parameter int unsigned IMG_W           = 2,
  parameter int unsigned DEFAULT_IMAGE   = 0,
  parameter int unsigned AUTOBOOT_CYCLES = 0,
  parameter int unsigned QUIESCE_CYCLES  = 16,
  parameter int unsigned BOOT_DELAY      = 256,
  parameter int unsigned PULSE_CYCLES    = 64,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned HB_W            = 24,
  parameter int unsigned LED_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             boot_req,
  input  logic [IMG_W-1:0] boot_image,
  input  logic             usb_activity,
  input  logic             flash_cs_n,
  output logic             user_programn,
  output logic [IMG_W-1:0] image_sel,
  output logic             booting,
  output logic [LED_W-1:0] led
);

  typedef enum logic [2:0] {StIdle, StQuiesce, StDelay, StPulse, StDone} state_e;

  localparam logic [IMG_W-1:0] DefImg      = IMG_W'(DEFAULT_IMAGE);
  localparam logic [CNT_W-1:0] AutoLast    = CNT_W'(AUTOBOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] QuiesceLast = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLim    = CNT_W'(BOOT_DELAY);
  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(PULSE_CYCLES - 1);
  localparam int unsigned      ImgLedW     = LED_W - 2;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  to_cnt;
  logic [HB_W-1:0]   hb_cnt;
  logic              hb;
  logic              img_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign img_ok = 32'(boot_image) < NUM_IMAGES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= StIdle;
      cnt           <= '0;
      to_cnt        <= '0;
      hb_cnt        <= '0;
      hb            <= 1'b0;
      user_programn <= 1'b1;
      image_sel     <= DefImg;
      booting       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          hb_cnt <= hb_cnt + HB_W'(1);
          if (&hb_cnt) hb <= ~hb;
          // Request beats timeout; activity beats timeout.
          if (boot_req) begin
            image_sel <= img_ok ? boot_image : DefImg;
            booting   <= 1'b1;
            cnt       <= '0;
            state     <= StQuiesce;
          end else if (usb_activity) begin
            to_cnt <= '0;
          end else if (AUTOBOOT_CYCLES != 0) begin
            if (to_cnt == AutoLast) begin
              image_sel <= DefImg;
              booting   <= 1'b1;
              cnt       <= '0;
              state     <= StQuiesce;
            end else begin
              to_cnt <= sat_inc(to_cnt);
            end
          end
        end
        StQuiesce: begin
          if (!flash_cs_n) begin
            cnt <= '0;
          end else if (cnt == QuiesceLast) begin
            cnt   <= '0;
            state <= StDelay;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        StDelay: begin
          if (!flash_cs_n) begin
            cnt   <= '0;
            state <= StQuiesce;
          end else if (cnt == DelayLim) begin
            cnt           <= '0;
            user_programn <= 1'b0;
            state         <= StPulse;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        StPulse: begin
          if (cnt == PulseLast) begin
            user_programn <= 1'b1;
            state         <= StDone;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        StDone: ;
        default: state <= StIdle;
      endcase
    end
  end

  // LEDs decode registered state only, so they change with the other outputs.
  assign led[0] = (state == StIdle) ? hb : 1'b1;
  assign led[1] = booting;

  if (LED_W > 2) begin : g_img_led
    assign led[LED_W-1:2] = (state == StIdle) ? '0 : ImgLedW'(image_sel);
  end

endmodule
